reg_wb_sequencer: RTL and testbench
===================================

# reg_wb_sequencer

Write-back sequencer for the 19-bit CPU, sitting directly upstream of general-purpose registers A, B and C. It accepts write-back requests (destination + data) through a valid/ready handshake and buffers them in a small FIFO. It issues at most one register load per cycle, driving the shared register data bus and a one-hot load strobe into each register's LOAD_REG input. An execution-side HOLD input stalls issue without losing queued writes.

## Interface
- WORD_SIZE, 19, data width of the registers and the write-back bus.
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- WB_VALID  in  1  write-back request present.
- WB_READY  out  1  sequencer can accept a request.
- WB_DEST  in  2  destination: 00=A, 01=B, 10=C, 11=discard.
- WB_DATA  in  WORD_SIZE  write-back value.
- HOLD  in  1  when high, no entry is popped or issued.
- LOAD_A / LOAD_B / LOAD_C  out  1 each  one-cycle load strobes to registers A/B/C; at most one high per cycle.
- REG_DATA  out  WORD_SIZE  data driven to the IN_DATA inputs of all three registers.
- PENDING  out  3  bit0/1/2 high while any FIFO entry targets A/B/C.
- COUNT  out  $clog2(DEPTH)+1  current FIFO occupancy.
- DISCARD_CNT  out  8  saturating count of accepted dest=11 requests.

## Operation
- Accept: a request is accepted on a rising edge where WB_VALID && WB_READY. It is written at the tail, and COUNT increments.
- WB_READY = (COUNT != DEPTH), combinational from state. A pop in the same cycle does not raise READY when the FIFO is full.
- Issue: on each edge where COUNT > 0 and HOLD == 0, the head entry is popped.
  - Destination 00/01/10: the matching LOAD_x is registered high for the following cycle, and REG_DATA is registered to the head data.
  - Destination 11: the entry is popped with no strobe and REG_DATA holds its value. It consumes the issue slot for that cycle.
- LOAD_* are low on every cycle in which no load was issued on the preceding edge.
- REG_DATA holds its last issued value when idle.
- Push and pop on the same edge: COUNT is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. COUNT never exceeds DEPTH and never underflows.
- PENDING is derived from the occupied entries only. An entry whose strobe is currently asserted is no longer pending.
- DISCARD_CNT increments on acceptance of dest=11 and saturates at 255.
- Ordering: loads are issued strictly in acceptance order. Two writes to the same register are both issued, and the later value wins.

## Timing
- Reset (asynchronous, RST_N low) values:
  - COUNT=0, pointers=0.
  - LOAD_A/B/C=0, REG_DATA=0.
  - PENDING=0, DISCARD_CNT=0.
  - WB_READY=1.
- Queued entries are lost on reset mid-operation, and no strobe is emitted during or after the reset.
- Baseline latency: accepted at edge k, popped at edge k+1 (if HOLD is low and it is at the head), strobe high during cycle k+1→k+2, register captures at edge k+2.
- HOLD is sampled on each edge. While it is high, strobes are low from the next cycle on and entries remain queued. Accepts continue until full.
- Sustained throughput is one load per cycle.

## Configuration
- WB_BYPASS_EN defined: an accepted request with dest ≠ 11 bypasses the FIFO when all of these hold on its acceptance edge:
  - COUNT == 0;
  - HOLD == 0;
  - no pop occurs on that edge.
  
  Its strobe is high during cycle k→k+1, and COUNT, PENDING and the pointers do not change.
- WB_BYPASS_EN undefined: every request passes through the FIFO with the baseline latency. No bypass logic is present.

## Test plan
- Reset, then a single write A=0x7FFFF with HOLD=0:
  - LOAD_A pulses for exactly one cycle, with REG_DATA=0x7FFFF.
  - Without bypass the pulse occurs one cycle after acceptance; with WB_BYPASS_EN it occurs on the acceptance edge.
- HOLD=1, push 4 writes (A=1, B=2, C=3, A=4):
  - WB_READY drops after the 4th, COUNT=4, PENDING=3'b111.
  - A 5th request is held off.
  - Release HOLD: strobes A, B, C, A appear on consecutive cycles with data 1, 2, 3, 4.
- Continuous push/pop at one per cycle for 20 writes:
  - COUNT stays constant, the pointers wrap at least 4 times, and every data value appears once in order.
- Dest=11 requests mixed with B writes:
  - The discard entries produce no strobe but take one issue slot each.
  - 300 discards leave DISCARD_CNT=255.
- RST_N asserted with COUNT=3 mid-issue:
  - Outputs go to their reset values immediately and no further strobes occur.
  - WB_READY=1 after release.
- HOLD toggled every other cycle with 3 queued writes:
  - Strobes occur only on cycles following edges where HOLD was low, and the order is preserved.

Source files
------------

// File: rtl/reg_wb_sequencer.sv
// Write-back sequencer: FIFO-buffered register loads for registers A/B/C.
// Optional same-cycle FIFO bypass when WB_BYPASS_EN is defined.
module reg_wb_sequencer #(
    parameter int WORD_SIZE = 19,
    parameter int DEPTH     = 4
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   WB_VALID,
    output logic                   WB_READY,
    input  logic [1:0]             WB_DEST,
    input  logic [WORD_SIZE-1:0]   WB_DATA,
    input  logic                   HOLD,
    output logic                   LOAD_A,
    output logic                   LOAD_B,
    output logic                   LOAD_C,
    output logic [WORD_SIZE-1:0]   REG_DATA,
    output logic [2:0]             PENDING,
    output logic [$clog2(DEPTH):0] COUNT,
    output logic [7:0]             DISCARD_CNT
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [1:0] DEST_DISCARD = 2'b11;

    logic [WORD_SIZE-1:0] r_data [DEPTH];
    logic [1:0]           r_dest [DEPTH];
    logic [PTR_W-1:0]     r_wptr;
    logic [PTR_W-1:0]     r_rptr;
    logic [CNT_W-1:0]     r_count;
    logic [2:0]           r_load;
    logic [WORD_SIZE-1:0] r_reg_data;
    logic [7:0]           r_disc;

    logic                 w_full;
    logic                 w_push;
    logic                 w_pop;
    logic                 w_bypass;
    logic                 w_enq;
    logic [2:0]           w_pending;

    function automatic logic [2:0] f_strobe(input logic [1:0] d);
        logic [2:0] s;
        s = 3'b000;
        case (d)
            2'b00:   s = 3'b001;
            2'b01:   s = 3'b010;
            2'b10:   s = 3'b100;
            default: s = 3'b000;
        endcase
        return s;
    endfunction

    always_comb begin
        w_full = (r_count == CNT_W'(DEPTH));
        w_push = WB_VALID && !w_full;
        w_pop  = (r_count != '0) && !HOLD;
    end

`ifdef WB_BYPASS_EN
    // An empty, unstalled FIFO lets a real write skip straight to the strobe.
    always_comb begin
        w_bypass = w_push && (WB_DEST != DEST_DISCARD) &&
                   (r_count == '0) && !HOLD && !w_pop;
    end
`else
    always_comb begin
        w_bypass = 1'b0;
    end
`endif

    always_comb begin
        w_enq = w_push && !w_bypass;
    end

    // An entry is pending only if it lies in the occupied window from the head.
    always_comb begin
        w_pending = 3'b000;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(PTR_W'(PTR_W'(i) - r_rptr)) < r_count) begin
                w_pending = w_pending | f_strobe(r_dest[i]);
            end
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_data[i] <= '0;
                r_dest[i] <= '0;
            end
            r_wptr <= '0;
        end else if (w_enq) begin
            r_data[r_wptr] <= WB_DATA;
            r_dest[r_wptr] <= WB_DEST;
            r_wptr         <= r_wptr + 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_enq, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_load     <= 3'b000;
            r_reg_data <= '0;
        end else if (w_pop) begin
            r_load     <= f_strobe(r_dest[r_rptr]);
            r_reg_data <= r_data[r_rptr];
        end else if (w_bypass) begin
            r_load     <= f_strobe(WB_DEST);
            r_reg_data <= WB_DATA;
        end else begin
            r_load     <= 3'b000;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_disc <= 8'd0;
        end else if (w_push && (WB_DEST == DEST_DISCARD) && (r_disc != 8'hFF)) begin
            r_disc <= r_disc + 8'd1;
        end
    end

    always_comb begin
        WB_READY    = !w_full;
        LOAD_A      = r_load[0];
        LOAD_B      = r_load[1];
        LOAD_C      = r_load[2];
        REG_DATA    = r_reg_data;
        PENDING     = w_pending;
        COUNT       = r_count;
        DISCARD_CNT = r_disc;
    end

endmodule

// File: tb/tb_reg_wb_sequencer.sv
// Self-checking bench for reg_wb_sequencer against a queue-based model.
// Works with or without WB_BYPASS_EN defined.
module tb_reg_wb_sequencer;

    localparam int W     = 19;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int VW    = 3 + W + CW + 3 + 8 + 1;

    logic          CLK = 1'b0;
    logic          RST_N = 1'b0;
    logic          WB_VALID = 1'b0;
    logic          WB_READY;
    logic [1:0]    WB_DEST = 2'b00;
    logic [W-1:0]  WB_DATA = '0;
    logic          HOLD = 1'b0;
    logic          LOAD_A, LOAD_B, LOAD_C;
    logic [W-1:0]  REG_DATA;
    logic [2:0]    PENDING;
    logic [CW-1:0] COUNT;
    logic [7:0]    DISCARD_CNT;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [1:0]   dest;
        logic [W-1:0] data;
    } ent_t;

    ent_t         mq[$];
    logic [2:0]   m_load;
    logic [W-1:0] m_data;
    logic [7:0]   m_disc;

    reg_wb_sequencer #(.WORD_SIZE(W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N), .WB_VALID(WB_VALID), .WB_READY(WB_READY),
        .WB_DEST(WB_DEST), .WB_DATA(WB_DATA), .HOLD(HOLD),
        .LOAD_A(LOAD_A), .LOAD_B(LOAD_B), .LOAD_C(LOAD_C),
        .REG_DATA(REG_DATA), .PENDING(PENDING), .COUNT(COUNT),
        .DISCARD_CNT(DISCARD_CNT)
    );

    always #5 CLK = ~CLK;

    function automatic logic [2:0] m_pend();
        logic [2:0] p;
        p = 3'b000;
        foreach (mq[i]) if (mq[i].dest != 2'b11) p[mq[i].dest] = 1'b1;
        return p;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {m_load, m_data, CW'(mq.size()), m_pend(), m_disc,
                (mq.size() != DEPTH)};
    endfunction

    function automatic logic [VW-1:0] act_vec();
        return {LOAD_C, LOAD_B, LOAD_A, REG_DATA, COUNT, PENDING,
                DISCARD_CNT, WB_READY};
    endfunction

    // Apply one cycle of inputs, advance the model over the edge, land at edge+1.
    task automatic drive(input logic v, input logic [1:0] d,
                         input logic [W-1:0] x, input logic h);
        logic acc, pop, byp;
        ent_t head;
        WB_VALID = v; WB_DEST = d; WB_DATA = x; HOLD = h;
        acc = v && (mq.size() != DEPTH);
        pop = (mq.size() != 0) && !h;
        byp = 1'b0;
`ifdef WB_BYPASS_EN
        byp = acc && (d != 2'b11) && (mq.size() == 0) && !h;
`endif
        m_load = 3'b000;
        if (pop) begin
            head = mq.pop_front();
            if (head.dest != 2'b11) m_load[head.dest] = 1'b1;
            m_data = head.data;
        end else if (byp) begin
            m_load[d] = 1'b1;
            m_data = x;
        end
        if (acc && !byp) mq.push_back('{dest: d, data: x});
        if (acc && d == 2'b11 && m_disc != 8'hFF) m_disc = m_disc + 8'd1;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0; WB_VALID = 1'b0; HOLD = 1'b0;
        mq.delete(); m_load = '0; m_data = '0; m_disc = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        if (act_vec() !== {3'b0, {W{1'b0}}, CW'(0), 3'b0, 8'd0, 1'b1}) begin
            errors++;
            $display("FAIL reset_vals act=%h req=%h", act_vec(),
                     {3'b0, {W{1'b0}}, CW'(0), 3'b0, 8'd0, 1'b1});
        end
        checks++;
    endtask

    task automatic test_single();
        int pulses = 0;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            if (c == 0) drive(1'b1, 2'b00, 19'h7FFFF, 1'b0);
            else drive(1'b0, 2'b00, W'($urandom), 1'b0);
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL single_cyc%0d act=%h req=%h", c, act_vec(), exp_vec());
            end
            checks++;
            if (LOAD_A) pulses++;
`ifdef WB_BYPASS_EN
            if (LOAD_A !== (c == 0)) begin
`else
            if (LOAD_A !== (c == 1)) begin
`endif
                errors++;
                $display("FAIL single_timing cyc%0d act=%b", c, LOAD_A);
            end
            checks++;
            if (LOAD_A && REG_DATA !== 19'h7FFFF) begin
                errors++;
                $display("FAIL single_data act=%h req=7ffff", REG_DATA);
            end
            checks++;
        end
        if (pulses != 1) begin
            errors++;
            $display("FAIL single_pulses act=%0d req=1", pulses);
        end
        checks++;
    endtask

    task automatic test_hold_fill();
        logic [2:0] exp_ld [4];
        logic [1:0] dst [4];
        exp_ld = '{3'b001, 3'b010, 3'b100, 3'b001};
        dst = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, dst[i], W'(i + 1), 1'b1);
        if ({WB_READY, COUNT, PENDING} !== {1'b0, CW'(4), 3'b111}) begin
            errors++;
            $display("FAIL hold_full act=%b/%0d/%b req=0/4/111", WB_READY, COUNT, PENDING);
        end
        checks++;
        drive(1'b1, 2'd1, 19'h5555, 1'b1);
        if (COUNT !== CW'(4) || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL hold_5th act=%h req=%h", act_vec(), exp_vec());
        end
        checks++;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 2'd0, '0, 1'b0);
            if ({LOAD_C, LOAD_B, LOAD_A} !== exp_ld[i] || REG_DATA !== W'(i + 1)) begin
                errors++;
                $display("FAIL hold_drain%0d act=%b/%h req=%b/%h", i,
                         {LOAD_C, LOAD_B, LOAD_A}, REG_DATA, exp_ld[i], i + 1);
            end
            checks++;
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 2; i++) drive(1'b1, 2'($urandom_range(2)), W'($urandom), 1'b1);
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 2'($urandom_range(2)), W'($urandom), 1'b0);
            if (COUNT !== CW'(2) || act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_cyc%0d act=%h req=%h", i, act_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_discard();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, (i % 2 == 0) ? 2'b11 : 2'b01, W'($urandom), 1'b0);
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL disc_mix%0d act=%h req=%h", i, act_vec(), exp_vec());
            end
            checks++;
        end
        for (int i = 0; i < 300; i++) drive(1'b1, 2'b11, W'($urandom), 1'b0);
        if (DISCARD_CNT !== 8'd255 || act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL disc_sat act=%0d req=255", DISCARD_CNT);
        end
        checks++;
    endtask

    task automatic test_reset_mid();
        int strobes = 0;
        do_reset();
        for (int i = 0; i < 4; i++) drive(1'b1, 2'(i % 3), W'($urandom), 1'b1);
        drive(1'b0, 2'd0, '0, 1'b0);
        if (COUNT !== CW'(3) || !LOAD_A) begin
            errors++;
            $display("FAIL rstmid_pre act=%0d/%b req=3/1", COUNT, LOAD_A);
        end
        checks++;
        #2;
        RST_N = 1'b0;
        mq.delete(); m_load = '0; m_data = '0; m_disc = '0;
        #1;
        if (act_vec() !== exp_vec()) begin
            errors++;
            $display("FAIL rstmid_async act=%h req=%h", act_vec(), exp_vec());
        end
        checks++;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 2'd0, '0, 1'b0);
            if (LOAD_A || LOAD_B || LOAD_C) strobes++;
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rstmid_after%0d act=%h req=%h", i, act_vec(), exp_vec());
            end
            checks++;
        end
        if (strobes != 0 || WB_READY !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_quiet act=%0d/%b req=0/1", strobes, WB_READY);
        end
        checks++;
    endtask

    task automatic test_hold_toggle();
        logic h;
        do_reset();
        drive(1'b1, 2'd1, W'($urandom), 1'b1);
        drive(1'b1, 2'd2, W'($urandom), 1'b1);
        drive(1'b1, 2'd0, W'($urandom), 1'b1);
        for (int i = 0; i < 8; i++) begin
            h = (i % 2 == 0);
            drive(1'b0, 2'd0, '0, h);
            if ((h && (LOAD_A || LOAD_B || LOAD_C)) || act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL toggle_cyc%0d act=%h req=%h", i, act_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 300; i++) begin
            drive(1'($urandom_range(1)), 2'($urandom), W'($urandom),
                  $urandom_range(3) == 0);
            if (act_vec() !== exp_vec()) begin
                errors++;
                $display("FAIL rand_cyc%0d act=%h req=%h", i, act_vec(), exp_vec());
            end
            checks++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hold_fill();
        test_back_to_back();
        test_discard();
        test_reset_mid();
        test_hold_toggle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
